// File: rtl/sample_wr_dma.sv
// Circular-buffer sample writer: input FIFO feeding single-beat AXI-lite writes at consecutive word addresses.
// Optional keep-one-in-DECIM decimation is compiled in with `define SAMPLE_WR_DMA_DECIM_EN.
module sample_wr_dma #(
  parameter int unsigned        ADDR_W      = 9,
  parameter int unsigned        DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = 9'h100,
  parameter int unsigned        DEPTH_WORDS = 32,
  parameter int unsigned        FIFO_DEPTH  = 4,
  parameter int unsigned        DECIM       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic              wrap_pulse,
  output logic              err,
  output logic [15:0]       wr_count
);

  localparam int unsigned       PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned       CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH_WORDS - 1));

  typedef enum logic [1:0] {IDLE, ADDR_DATA, RESP} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_empty;
  logic               accept, push, pop;
  logic [DATA_W-1:0]  head;

  logic [ADDR_W-1:0]  awaddr_d;
  logic               awvalid_d, wvalid_d, bready_d, wrap_d, err_d;
  logic [DATA_W-1:0]  wdata_d;
  logic [15:0]        wr_count_d;

  // Ready depends only on the registered occupancy, so a same-cycle pop never frees a slot early.
  assign sample_ready = en & (fifo_cnt != FULL_CNT);
  assign accept       = sample_valid & sample_ready;
  assign fifo_empty   = (fifo_cnt == '0);
  assign head         = mem[rd_ptr];
  assign wstrb        = 4'hF;

`ifdef SAMPLE_WR_DMA_DECIM_EN
  localparam int unsigned DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  logic [DC_W-1:0] decim_cnt;

  // Every accepted sample advances the phase; only phase 0 reaches the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_cnt <= '0;
    end else if (accept) begin
      decim_cnt <= (decim_cnt == DC_W'(DECIM - 1)) ? '0 : decim_cnt + DC_W'(1);
    end
  end

  assign push = accept & (decim_cnt == '0);
`else
  localparam int unsigned unused_decim = DECIM;
  assign push = accept;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      awaddr     <= BASE_ADDR;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      wdata      <= '0;
      bready     <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
      wr_count   <= '0;
    end else begin
      state_q    <= state_d;
      awaddr     <= awaddr_d;
      awvalid    <= awvalid_d;
      wvalid     <= wvalid_d;
      wdata      <= wdata_d;
      bready     <= bready_d;
      wrap_pulse <= wrap_d;
      err        <= err_d;
      wr_count   <= wr_count_d;
    end
  end

  // Address and data channels complete independently; the response phase starts once both have.
  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr;
    awvalid_d  = awvalid;
    wvalid_d   = wvalid;
    wdata_d    = wdata;
    bready_d   = bready;
    wrap_d     = 1'b0;
    err_d      = err;
    wr_count_d = wr_count;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          wdata_d   = head;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (bvalid) begin
          bready_d   = 1'b0;
          wr_count_d = wr_count + 16'd1;
          if (bresp != 2'b00) err_d = 1'b1;
          if (awaddr == LAST_ADDR) begin
            awaddr_d = BASE_ADDR;
            wrap_d   = 1'b1;
          end else begin
            awaddr_d = awaddr + ADDR_W'(4);
          end
          if (!fifo_empty) begin
            pop       = 1'b1;
            wdata_d   = head;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ADDR_DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sample_wr_dma.sv
// Scoreboard bench for sample_wr_dma: stimulus queues expected address/data, a negedge monitor checks the bus.
module tb_sample_wr_dma;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DECIM = 2;
  localparam logic [8:0]  BASE  = 9'h100;

  logic        clk = 1'b0;
  logic        reset, en, sample_valid, sample_ready;
  logic [31:0] sample_data, wdata;
  logic [8:0]  awaddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        wrap_pulse, err;
  logic [15:0] wr_count;

  sample_wr_dma #(
    .ADDR_W(9), .DATA_W(32), .BASE_ADDR(9'h100), .DEPTH_WORDS(DEPTH), .FIFO_DEPTH(4), .DECIM(DECIM)
  ) dut (
    .clk(clk), .reset(reset), .en(en),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .sample_data(sample_data),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wrap_pulse(wrap_pulse), .err(err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [8:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int wr_idx = 0, dcnt = 0, kept = 0;
  int aw_delay = 0, w_delay = 0, err_idx = -1;

  // slave state
  int aw_cnt = 0, w_cnt = 0, b_idx = 0;
  bit aw_done = 0, w_done = 0, aw_hs = 0, w_hs = 0, b_hs = 0;

  // monitor model
  int resp_cnt = 0, wrap_seen = 0;
  bit err_exp = 0, wrap_exp = 0, aw_stall = 0, w_stall = 0;
  logic [8:0]  stall_addr;
  logic [31:0] stall_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    bit keep;
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    while (!sample_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      check("send_timeout", 32'(sample_ready), 32'd1);
    end else begin
`ifdef SAMPLE_WR_DMA_DECIM_EN
      keep = (dcnt == 0);
      dcnt = (dcnt + 1) % DECIM;
`else
      keep = 1'b1;
`endif
      if (keep) begin
        exp_addr_q.push_back(BASE + 9'(4 * (wr_idx % DEPTH)));
        exp_data_q.push_back(d);
        wr_idx++;
        kept++;
      end
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (wr_count != 16'(kept) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_wr_count", 32'(wr_count), 32'(kept));
    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 32'(exp_addr_q.size() + exp_data_q.size()), 32'd0);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #2;
    exp_addr_q.delete();
    exp_data_q.delete();
    wr_idx = 0; dcnt = 0; kept = 0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    release_reset();
  endtask

  // AXI-lite slave: programmable ready delays; bresp=2'b10 on the response numbered err_idx.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(posedge clk or posedge reset); #1;
      if (reset) begin
        aw_cnt = 0; w_cnt = 0; b_idx = 0;
        aw_done = 0; w_done = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      end else begin
        if (aw_hs) aw_done = 1;
        if (w_hs)  w_done  = 1;
        if (b_hs) begin aw_done = 0; w_done = 0; b_idx++; end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        bvalid = aw_done && w_done;
        bresp  = (b_idx == err_idx) ? 2'b10 : 2'b00;
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
      end
    end
  end

  // Monitor: handshakes happen at the posedge following this negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        resp_cnt = 0; wrap_seen = 0; err_exp = 0; wrap_exp = 0; aw_stall = 0; w_stall = 0;
      end else begin
        check("wr_count", 32'(wr_count), 32'(resp_cnt % 65536));
        check("wrap_pulse", 32'(wrap_pulse), 32'(wrap_exp));
        check("err", 32'(err), 32'(err_exp));
        if (wrap_pulse) wrap_seen++;
        if (aw_stall) begin
          check("awvalid_hold", 32'(awvalid), 32'd1);
          check("awaddr_stable", 32'(awaddr), 32'(stall_addr));
        end
        if (w_stall) begin
          check("wvalid_hold", 32'(wvalid), 32'd1);
          check("wdata_stable", wdata, stall_data);
        end
        if (awvalid && awready) begin
          if (exp_addr_q.size() == 0) check("awaddr_unexpected", 32'(awaddr), 32'hFFFF_FFFF);
          else check("awaddr", 32'(awaddr), 32'(exp_addr_q.pop_front()));
        end
        if (wvalid && wready) begin
          if (exp_data_q.size() == 0) check("wdata_unexpected", wdata, ~wdata);
          else check("wdata", wdata, exp_data_q.pop_front());
          check("wstrb", 32'(wstrb), 32'hF);
        end
        aw_stall   = awvalid && !awready;
        stall_addr = awaddr;
        w_stall    = wvalid && !wready;
        stall_data = wdata;
        if (bvalid && bready) begin
          wrap_exp = ((resp_cnt % DEPTH) == DEPTH - 1);
          err_exp  = err_exp | (bresp != 2'b00);
          resp_cnt++;
        end else begin
          wrap_exp = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_data = '0;
    #12;
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    check("rst_awaddr", 32'(awaddr), 32'h100);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_wrap_pulse", 32'(wrap_pulse), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    release_reset();
    en = 1'b1;

    // three samples, zero-wait slave
    send(32'hA0); send(32'hA1); send(32'hA2);
    drain();
    check("basic_wr_count", 32'(wr_count), 32'(kept));
    check("basic_err", 32'(err), 32'd0);

    // 33 samples: wrap back to word 0
    do_reset();
    for (int i = 0; i < 33; i++) send(32'h1000 + 32'(i));
    drain();
    check("wrap_once", 32'(wrap_seen), (kept >= 32) ? 32'd1 : 32'd0);

    // stalled slave, wready before awready: FIFO fills
    do_reset();
    aw_delay = 5; w_delay = 2;
    for (int i = 0; i < 5; i++) send(32'hB0 + 32'(i));
`ifndef SAMPLE_WR_DMA_DECIM_EN
    check("full_ready_low", 32'(sample_ready), 32'd0);
`endif
    send(32'hB5);
    drain();
    aw_delay = 0; w_delay = 0;

    // error response on 2nd write, sticky err
    do_reset();
    err_idx = 1;
    send(32'hC0); send(32'hC1); send(32'hC2);
    drain();
    check("err_set", 32'(err), 32'd1);
    err_idx = -1;
    send(32'hC3);
    drain();
    check("err_sticky", 32'(err), 32'd1);

    // reset while in RESP of the 2nd write
    do_reset();
    send(32'hD0); send(32'hD1);
    n = 0;
    @(negedge clk);
    while (!(bready && wr_count == 16'd1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("resp_reached", 32'(bready && wr_count == 16'd1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_awvalid", 32'(awvalid), 32'd0);
    check("midrst_wvalid", 32'(wvalid), 32'd0);
    check("midrst_bready", 32'(bready), 32'd0);
    check("midrst_awaddr", 32'(awaddr), 32'h100);
    check("midrst_wr_count", 32'(wr_count), 32'd0);
    release_reset();
    send(32'hE0); send(32'hE1);
    drain();

    // samples 1..6 (decimated build keeps 1,3,5)
    do_reset();
    for (int i = 1; i <= 6; i++) send(32'(i));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
